alu_result_stage: RTL
=====================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of result-buffer entries (legal values 2 or 4).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port N_RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port IN_VALID  input  1  upstream ALU result present this cycle.
REQ-005 SHALL have port IN_READY  output  1  stage can accept a result this cycle.
REQ-006 SHALL have port ALU_OUT  input  16  ALU result word.
REQ-007 SHALL have port FLAG_IN  input  4  ALU flags {S,Z,C,V}.
REQ-008 SHALL have port S_ALU  input  4  ALU opcode of this result; 4'b1111 = no-op.
REQ-009 SHALL have port DEST_REG  input  3  destination register index.
REQ-010 SHALL have port REG_WE  input  1  result is to be written to DEST_REG.
REQ-011 SHALL have port FLAG_WE  input  1  result updates the flag register.
REQ-012 SHALL have port BR_EN  input  1  instruction is a conditional branch.
REQ-013 SHALL have port BR_COND  input  3  branch condition code (REQ-021).
REQ-014 SHALL have port OUT_VALID  output  1  head entry valid for writeback.
REQ-015 SHALL have port OUT_READY  input  1  writeback consumes head entry.
REQ-016 SHALL have port WB_DATA  output  16  head entry result.
REQ-017 SHALL have port WB_REG  output  3  head entry destination.
REQ-018 SHALL have port WB_WE  output  1  head entry register write enable.
REQ-019 SHALL have port BR_TAKEN  output  1  head entry branch resolved taken.
REQ-020 SHALL have port FLAGS  output  4  committed flag register {S,Z,C,V}.

Function
REQ-021 SHALL evaluate BR_COND against FLAGS: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 S!=V, 110 S==V, 111 V.
REQ-022 SHALL accept (push) when IN_VALID && IN_READY at a rising edge; pop when OUT_VALID && OUT_READY.
REQ-023 SHALL drive IN_READY = (count < DEPTH), combinationally from registered count only (no IN_VALID/OUT_READY path).
REQ-024 SHALL store per entry {ALU_OUT, DEST_REG, REG_WE, BR_TAKEN}; BR_TAKEN = BR_EN && condition(FLAGS value before this edge).
REQ-025 SHALL update FLAGS <= FLAG_IN on push when FLAG_WE=1 and S_ALU!=4'b1111; otherwise FLAGS hold.
REQ-026 SHALL make branch evaluation of a beat use pre-update FLAGS even if the same beat has FLAG_WE=1.
REQ-027 SHALL present head entry on WB_* / BR_TAKEN with OUT_VALID=1 when count>0; latency push-to-OUT_VALID = 1 cycle.
REQ-028 SHALL drive WB_DATA=0, WB_REG=0, WB_WE=0, BR_TAKEN=0 while count==0.
REQ-029 SHALL keep head outputs stable while OUT_VALID=1 and OUT_READY=0.
REQ-030 SHALL, on simultaneous push and pop, leave count unchanged and preserve order; when full, push is refused (IN_READY=0) even if pop occurs same cycle.
REQ-031 SHALL wrap read/write pointers modulo DEPTH; entries delivered strictly in FIFO order.
REQ-032 SHALL ignore IN_VALID when IN_READY=0 (no state change, no flag update).

Reset
REQ-033 SHALL on N_RST=0 asynchronously clear count, pointers, FLAGS=4'b0000; OUT_VALID=0, IN_READY=1 within the reset assertion, independent of CLK.
REQ-034 SHALL discard buffered entries on reset asserted mid-operation; first post-release push behaves as from empty.
REQ-035 SHALL begin accepting at the first rising edge after N_RST deasserts.

Verification
REQ-036 Single push ALU_OUT=16'h1234, DEST_REG=3, REG_WE=1, OUT_READY=1 -> next cycle OUT_VALID=1, WB_DATA=16'h1234, WB_REG=3, WB_WE=1; following cycle OUT_VALID=0.
REQ-037 OUT_READY=0, push 3 beats (DEPTH=2) -> IN_READY=0 after 2nd, 3rd refused; release OUT_READY -> beats 1,2 out in order, IN_READY=1.
REQ-038 Push FLAG_WE=1, FLAG_IN=4'b0100 (Z) then BR_EN=1, BR_COND=001 -> FLAGS=4'b0100, second entry BR_TAKEN=1; same with BR_COND=010 -> BR_TAKEN=0.
REQ-039 Same-beat FLAG_WE=1 FLAG_IN=4'b0100, BR_EN=1, BR_COND=001 with FLAGS=0 -> BR_TAKEN=0, FLAGS becomes 4'b0100; S_ALU=4'b1111 with FLAG_WE=1 -> FLAGS unchanged.
REQ-040 Count=1, simultaneous push 16'hAAAA and pop 16'h5555 -> count stays 1, next head 16'hAAAA.
REQ-041 Assert N_RST low between edges with 2 entries, FLAGS=4'b1001 -> immediately OUT_VALID=0, FLAGS=0, IN_READY=1; no stale entry after release.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result buffer: a small FIFO of writeback entries with branch resolution
// against the committed flag register.
module alu_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] ALU_OUT,
    input  logic [3:0]  FLAG_IN,
    input  logic [3:0]  S_ALU,
    input  logic [2:0]  DEST_REG,
    input  logic        REG_WE,
    input  logic        FLAG_WE,
    input  logic        BR_EN,
    input  logic [2:0]  BR_COND,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] WB_DATA,
    output logic [2:0]  WB_REG,
    output logic        WB_WE,
    output logic        BR_TAKEN,
    output logic [3:0]  FLAGS
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        we;
        logic        br;
    } entry_t;

    entry_t             entry_mem [DEPTH];
    entry_t             new_entry;
    entry_t             head_entry;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [3:0]         flags_reg;
    logic               push;
    logic               pop;

    // Flags are {S,Z,C,V}.
    function automatic logic cond_met(input logic [3:0] f, input logic [2:0] c);
        logic s, z, cy, v;
        {s, z, cy, v} = f;
        case (c)
            3'b000:  return 1'b1;
            3'b001:  return z;
            3'b010:  return !z;
            3'b011:  return cy;
            3'b100:  return !cy;
            3'b101:  return s != v;
            3'b110:  return s == v;
            default: return v;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy, so no input-to-ready path.
    assign IN_READY  = count_reg < CNT_W'(DEPTH);
    assign OUT_VALID = count_reg != '0;
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    // Branches resolve against the flags committed before this beat.
    assign new_entry = '{data: ALU_OUT, dest: DEST_REG, we: REG_WE,
                         br: BR_EN && cond_met(flags_reg, BR_COND)};

    always_ff @(posedge CLK) begin
        if (push) begin
            entry_mem[wr_ptr_reg] <= new_entry;
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            flags_reg  <= 4'b0000;
        end else begin
            if (push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
                if (FLAG_WE && S_ALU != OP_NOP) begin
                    flags_reg <= FLAG_IN;
                end
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = entry_mem[rd_ptr_reg];
    assign WB_DATA    = OUT_VALID ? head_entry.data : '0;
    assign WB_REG     = OUT_VALID ? head_entry.dest : '0;
    assign WB_WE      = OUT_VALID && head_entry.we;
    assign BR_TAKEN   = OUT_VALID && head_entry.br;
    assign FLAGS      = flags_reg;

endmodule
